// File: rtl/dmrs_pkg.sv
// Shared types and constants for the PUSCH DMRS generator.
// The DMRS_WR_ADDR_EN build option is handled in dmrs_gen.sv.
package dmrs_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, DONE} state_t;

  localparam int GOLD_LEN    = 31;
  localparam int NC          = 1600;
  localparam int WARM_CYCLES = NC / 2;
  localparam int CNT_W       = 10;

  localparam logic [GOLD_LEN-1:0] X1_INIT = 31'h1;
endpackage

// File: rtl/dmrs_gold_lfsr.sv
// Length-31 Gold sequence pair (x1, x2), advanced two steps per enable.
// c_next is the c-bit pair that sits at the head once the pending advance lands.
module dmrs_gold_lfsr
  import dmrs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [GOLD_LEN-1:0] c_init,
  output logic [1:0]          c_next
);
  logic [GOLD_LEN-1:0] x1, x2;
  logic                x1_a, x1_b, x2_a, x2_b;

  // Bit k holds x(n+k); two new bits enter at the top per advance.
  assign x1_a = x1[3] ^ x1[0];
  assign x1_b = x1[4] ^ x1[1];
  assign x2_a = x2[3] ^ x2[2] ^ x2[1] ^ x2[0];
  assign x2_b = x2[4] ^ x2[3] ^ x2[2] ^ x2[1];

  assign c_next = {x1[3] ^ x2[3], x1[2] ^ x2[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0;
      x2 <= '0;
    end else if (load) begin
      x1 <= X1_INIT;
      x2 <= c_init;
    end else if (advance) begin
      x1 <= {x1_b, x1_a, x1[GOLD_LEN-1:2]};
      x2 <= {x2_b, x2_a, x2[GOLD_LEN-1:2]};
    end
  end
endmodule

// File: rtl/dmrs_gen.sv
// PUSCH DMRS generator: Gold sequence warm-up, QPSK mapping, valid/ready output.
// Define DMRS_WR_ADDR_EN to add DMRS_Wr_en / DMRS_Wr_addr for filling the DMRS memory.
module dmrs_gen
  import dmrs_pkg::*;
#(
  parameter int DMRS_Len = 9,
  parameter int DMRS_AMP = 181
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Start,
  input  logic [30:0]                C_init,
  input  logic [6:0]                 N_rb,
  input  logic                       Dmrs_Ready,
  output logic signed [DMRS_Len-1:0] Dmrs_I,
  output logic signed [DMRS_Len-1:0] Dmrs_Q,
  output logic                       DMRS_Valid,
  output logic                       DMRS_Done,
  output logic                       Busy
`ifdef DMRS_WR_ADDR_EN
  ,
  output logic                       DMRS_Wr_en,
  output logic [CNT_W-1:0]           DMRS_Wr_addr
`endif
);
  localparam logic signed [DMRS_Len-1:0] AMP_POS   = DMRS_Len'(DMRS_AMP);
  localparam logic signed [DMRS_Len-1:0] AMP_NEG   = -AMP_POS;
  localparam logic [CNT_W-1:0]           WARM_LAST = CNT_W'(WARM_CYCLES - 1);

  state_t              state;
  logic [GOLD_LEN-1:0] c_init_q;
  logic [6:0]          n_rb_q;
  logic [CNT_W-1:0]    cnt, warm, last_idx;
  logic [1:0]          c_next;
  logic                xfer;

  function automatic logic signed [DMRS_Len-1:0] qpsk(input logic b);
    return b ? AMP_NEG : AMP_POS;
  endfunction

  assign xfer     = (state == GEN) && DMRS_Valid && Dmrs_Ready;
  assign last_idx = CNT_W'(n_rb_q) * CNT_W'(6) - CNT_W'(1);

  dmrs_gold_lfsr u_lfsr (
    .clk     (CLK),
    .rst     (RST),
    .load    (state == LOAD),
    .advance ((state == WARM) || xfer),
    .c_init  (c_init_q),
    .c_next  (c_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      c_init_q   <= '0;
      n_rb_q     <= '0;
      cnt        <= '0;
      warm       <= '0;
      Dmrs_I     <= '0;
      Dmrs_Q     <= '0;
      DMRS_Valid <= 1'b0;
      DMRS_Done  <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      DMRS_Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          c_init_q <= C_init;
          n_rb_q   <= N_rb;
          Busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          warm  <= WARM_LAST;
          state <= WARM;
        end
        // The last warm-up advance exposes c(0), c(1) through c_next.
        WARM: if (warm == '0) begin
          if (n_rb_q == '0) begin
            DMRS_Done <= 1'b1;
            state     <= DONE;
          end else begin
            DMRS_Valid <= 1'b1;
            Dmrs_I     <= qpsk(c_next[0]);
            Dmrs_Q     <= qpsk(c_next[1]);
            state      <= GEN;
          end
        end else begin
          warm <= warm - CNT_W'(1);
        end
        GEN: if (xfer) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == last_idx) begin
            DMRS_Valid <= 1'b0;
            DMRS_Done  <= 1'b1;
            Dmrs_I     <= '0;
            Dmrs_Q     <= '0;
            state      <= DONE;
          end else begin
            Dmrs_I <= qpsk(c_next[0]);
            Dmrs_Q <= qpsk(c_next[1]);
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMRS_WR_ADDR_EN
  assign DMRS_Wr_en   = xfer;
  assign DMRS_Wr_addr = cnt;
`endif
endmodule

// File: doc/dmrs_gen.md
# dmrs_gen

PUSCH DMRS sequence generator, the stage directly upstream of the resource element mapper. Given `c_init` and the RB allocation, it runs the 3GPP length-31 Gold sequence (Nc = 1600) and QPSK-maps it into fixed-point I/Q pairs. It emits exactly 6·N_rb DMRS symbols (type-1 comb, 6 REs per RB) on a valid/ready stream. The mapper consumes them through its DMRS valid/done inputs, or through the DMRS memory when write-address mode is compiled in.

## Interface
Parameters:
- DMRS_Len, 9 — signed width of each I/Q output sample
- DMRS_AMP, 181 — QPSK magnitude, ≈ 2^(DMRS_Len-1)/√2; must be < 2^(DMRS_Len-1)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  block clock
- RST  in  1  synchronous, active-high reset
- Start  in  1  single-cycle request; sampled only in IDLE
- C_init  in  31  Gold scrambling init, latched on accepted Start
- N_rb  in  7  allocated RBs, latched on accepted Start; 0 is legal
- Dmrs_Ready  in  1  consumer ready
- Dmrs_I  out  DMRS_Len  signed I sample
- Dmrs_Q  out  DMRS_Len  signed Q sample
- DMRS_Valid  out  1  sample valid
- DMRS_Done  out  1  one-cycle pulse after the last transfer
- Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE → LOAD → WARM → GEN → DONE → IDLE.
- IDLE: Start=1 latches C_init and N_rb, then goes to LOAD. Start is ignored in every other state.
- LOAD (1 cycle): loads x1 = 31'h0000_0001 (x1(0)=1, others 0) and x2 = C_init (bit k = x2(k)). Clears the output counter.
- WARM: exactly 800 cycles. Each cycle advances both LFSRs by two steps, 1600 steps total:
  - x1(n+31) = x1(n+3) ^ x1(n)
  - x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
- GEN:
  - If latched N_rb = 0, go straight to DONE.
  - Otherwise, the output register holds c(2m), c(2m+1), where c = x1 ^ x2 at the current LFSR head.
  - Mapping: bit 0 → +DMRS_AMP, bit 1 → −DMRS_AMP. I uses c(2m); Q uses c(2m+1).
  - Each transfer (Valid & Ready) advances the LFSRs two steps and increments the counter.
  - After transfer number 6·N_rb, go to DONE.
- DONE (1 cycle): DMRS_Done=1, then IDLE.
- Counter is 10 bits; the maximum is 6·127 = 762, so there is no overflow.

## Timing
- Reset values: Dmrs_I=0, Dmrs_Q=0, DMRS_Valid=0, DMRS_Done=0, Busy=0; state=IDLE; LFSRs and counter cleared.
- Reset in any state aborts the run in the same cycle. No Done is produced.
- Start sampled at cycle 0 → LOAD in cycle 1 → WARM cycles 2..801 → first DMRS_Valid in cycle 802.
- With Ready held high, one sample per cycle. The last Valid is in cycle 801+6·N_rb; Done follows in the next cycle.
- N_rb=0: Done in cycle 802, no Valid.
- Backpressure: while Valid=1 and Ready=0, Dmrs_I/Q stay stable and the LFSRs freeze.
- Valid never drops before its transfer completes.
- Ready has no effect outside GEN.
- DMRS_Valid is registered and does not depend combinationally on Ready.
- Start asserted in the DONE cycle is ignored. A new run needs Start in IDLE.

## Configuration
- DMRS_WR_ADDR_EN defined:
  - Adds outputs DMRS_Wr_en (1) and DMRS_Wr_addr (10).
  - DMRS_Wr_en = Valid & Ready.
  - DMRS_Wr_addr = counter value of the current sample: 0 for the first sample, incrementing per transfer.
  - Both reset to 0.
  - This lets the block fill the DMRS memory that the mapper reads by address.
- Undefined: these ports are absent and the block is pure streaming. All other behaviour is identical.

## Structure
- Package `dmrs_pkg` holds:
  - state enum (IDLE, LOAD, WARM, GEN, DONE)
  - GOLD_LEN=31, NC=1600, WARM_CYCLES=800
  - X1_INIT=31'h1
  - counter width (10)
- Sub-module `dmrs_gold_lfsr` holds x1/x2 and advances them by two steps per enable. It has load and advance inputs and outputs the two c bits.
- The top holds the FSM, counter, QPSK mapping and output register.

## Test plan
- Reset, then C_init=0, N_rb=1, Ready=1 → first Valid in cycle 802 after Start. Six samples, each ±181 on I and Q and bit-exact against the golden model. Done pulses one cycle after the 6th sample.
- N_rb=106, random C_init, Ready=1 → exactly 636 transfers, bit-exact, continuous Valid. DMRS_Done and Busy fall correctly.
- N_rb=0 → no Valid; Done in cycle 802; Busy low in cycle 803.
- N_rb=2 with Ready toggling (3 low / 1 high) → values held while stalled, 12 transfers total, sequence unchanged versus the Ready=1 run.
- RST asserted mid-GEN (after 5 transfers) → all outputs 0 in the next cycle. A following Start restarts the sequence from its first sample.
- With DMRS_WR_ADDR_EN, N_rb=3 → DMRS_Wr_addr runs 0..17 and DMRS_Wr_en matches the transfers. Extra Start pulses while Busy are ignored.
